// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side control blocks: state encoding
// and the width helper used to size owner indices and beat counters.
package fifo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Ceiling log2; values up to 2**30 are enough for every width derived here.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after rr_ptr_i, wrapping modulo N_REQ.
// Purely combinational rotate / priority-encode / rotate-back.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;
  logic [IDX_W:0]     sum;

  always_comb begin
    dbl = {req_i, req_i} >> rr_ptr_i;
    rot = dbl[N_REQ-1:0];
    enc = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    valid_o = |rot;
    sum = {1'b0, rr_ptr_i} + {1'b0, enc};
    if (sum >= N_L) sum = sum - N_L;
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting contiguous bursts of up to BURST_LEN beats and stalling on wfull.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4,
  parameter int IDX_W     = clog2(N_REQ),
  parameter int CNT_W     = clog2(BURST_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       ack,
  input  logic                   wfull,
  output logic                   winc,
  output logic [WIDTH-1:0]       wdata,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Handshake: a beat moves when req[owner] is high and wfull is low while
  // busy; ack[owner] pulses in that cycle and the producer then advances.
  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             own_req, own_last;
  logic [WIDTH-1:0] wdata_sel;
  logic             winc_w;
  logic             burst_end;

  assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
  // At end of burst the rescan starts after the owner, so the owner comes last.
  assign pick_ptr  = (state_q == ST_BURST) ? owner_nxt : rr_ptr_q;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (pick_ptr),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_comb begin
    wdata_sel = '0;
    own_req   = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        wdata_sel = req_data[i*WIDTH +: WIDTH];
        own_req   = req[i];
        own_last  = req_last[i];
      end
    end
  end

  assign winc_w    = (state_q == ST_BURST) && own_req && !wfull;
  assign burst_end = (state_q == ST_BURST) &&
                     (!own_req || (winc_w && (own_last || beat_cnt_q == LAST_BEAT)));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          rr_ptr_d   = owner_nxt;
          beat_cnt_d = '0;
          if (pick_valid) owner_d = pick_idx;
          else            state_d = ST_IDLE;
        end else if (winc_w) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = winc_w && (owner_q == IDX_W'(i));
    end
  end

  assign winc  = winc_w;
  assign wdata = winc_w ? wdata_sel : '0;
  assign owner = owner_q;
  assign busy  = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queued producers, a grant-level reference model
// checked every cycle, and a write-log scoreboard against hand-built sequences.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int N_REQ     = 4;
  localparam int BURST_LEN = 4;
  localparam int IDX_W     = 2;
  localparam int PDEPTH    = 16;

  // ---------------- clock / reset ----------------
  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_last = '0;
  logic [N_REQ-1:0]       ack;
  logic                   wfull = 1'b0;
  logic                   winc;
  logic [WIDTH-1:0]       wdata;
  logic [IDX_W-1:0]       owner;
  logic                   busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .N_REQ     (N_REQ),
    .BURST_LEN (BURST_LEN),
    .IDX_W     (IDX_W),
    .CNT_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- producers ----------------
  logic [8:0]       pbuf [N_REQ][PDEPTH];
  int               phead [N_REQ];
  int               ptail [N_REQ];
  logic [N_REQ-1:0] ack_seen = '0;

  task automatic load(input int p, input logic [7:0] d, input logic l);
    pbuf[p][ptail[p]] = {l, d};
    ptail[p]++;
  endtask

  task automatic drive();
    for (int p = 0; p < N_REQ; p++) begin
      if (phead[p] < ptail[p]) begin
        req[p]                  = 1'b1;
        req_data[p*WIDTH +: WIDTH] = pbuf[p][phead[p]][7:0];
        req_last[p]             = pbuf[p][phead[p]][8];
      end else begin
        req[p]                  = 1'b0;
        req_data[p*WIDTH +: WIDTH] = '0;
        req_last[p]             = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < N_REQ; p++) if (ack_seen[p]) phead[p]++;
    drive();
  endtask

  function automatic bit drained();
    for (int p = 0; p < N_REQ; p++) if (phead[p] < ptail[p]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  // Grant-level view: who holds the grant, how many beats it has written,
  // and where the next round-robin scan starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_done  = 0;
  int m_next  = 0;

  function automatic int pick(input int start, input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) if (v[(start + k) % N_REQ]) return (start + k) % N_REQ;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int p;
    bit w;
    bit fin;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_done = 0; m_next = 0;
    end else if (!m_busy) begin
      p = pick(m_next, req);
      if (p >= 0) begin m_busy = 1'b1; m_owner = p; m_done = 0; end
    end else begin
      w = req[m_owner] && !wfull;
      if (w) m_done++;
      fin = !req[m_owner] || (w && (req_last[m_owner] || m_done == BURST_LEN));
      if (fin) begin
        m_next = (m_owner + 1) % N_REQ;
        p = pick(m_next, req);
        m_done = 0;
        if (p >= 0) m_owner = p;
        else        m_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               exp_own[$];
  logic [WIDTH-1:0] log_data[$];
  int               log_own[$];
  int               log_cyc[$];

  always @(negedge clk) begin : compare
    logic             e_winc;
    logic [N_REQ-1:0] e_ack;
    logic [WIDTH-1:0] e_wdata;
    e_winc  = m_busy && req[m_owner] && !wfull;
    e_ack   = e_winc ? (N_REQ'(1) << m_owner) : '0;
    e_wdata = e_winc ? req_data[m_owner*WIDTH +: WIDTH] : '0;
    check("winc",  32'(winc),  32'(e_winc));
    check("ack",   32'(ack),   32'(e_ack));
    check("wdata", 32'(wdata), 32'(e_wdata));
    check("busy",  32'(busy),  32'(m_busy));
    check("owner", 32'(owner), 32'(m_owner));
    if (winc) begin
      log_data.push_back(wdata);
      log_own.push_back(int'(owner));
      log_cyc.push_back(cyc);
    end
    ack_seen = ack;
  end

  task automatic expect_beat(input int o, input logic [7:0] d);
    exp_q.push_back(d);
    exp_own.push_back(o);
  endtask

  task automatic check_log(input string name);
    int n;
    check({name, "_count"}, 32'(log_data.size()), 32'(exp_q.size()));
    n = (log_data.size() < exp_q.size()) ? log_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_data"},  32'(log_data[i]), 32'(exp_q[i]));
      check({name, "_owner"}, 32'(log_own[i]),  32'(exp_own[i]));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(drained() && !busy) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, budget);
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wfull = 1'b0;
    for (int p = 0; p < N_REQ; p++) begin phead[p] = 0; ptail[p] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); exp_own.delete();
    log_data.delete(); log_own.delete(); log_cyc.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t_req;
    int n;

    // Reset and idle
    do_reset();
    repeat (10) step();
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_winc",  32'(winc),  32'd0);
    check("idle_ack",   32'(ack),   32'd0);

    // Single producer, two back-to-back full bursts
    do_reset();
    for (int k = 0; k < 8; k++) begin
      load(2, 8'h10 + 8'(k), 1'b0);
      expect_beat(2, 8'h10 + 8'(k));
    end
    drive();
    t_req = cyc;
    wait_idle("single", 60);
    check_log("single");
    if (log_cyc.size() == 8) begin
      check("single_latency", 32'(log_cyc[0] - t_req), 32'd1);
      check("single_contig",  32'(log_cyc[7] - log_cyc[0]), 32'd7);
    end

    // Round-robin with all producers requesting
    do_reset();
    for (int o = 0; o < N_REQ; o++)
      for (int k = 0; k < 8; k++) load(o, 8'h40 + 8'(o * 16 + k), 1'b0);
    for (int r = 0; r < 2; r++)
      for (int o = 0; o < N_REQ; o++)
        for (int k = 0; k < 4; k++) expect_beat(o, 8'h40 + 8'(o * 16 + r * 4 + k));
    drive();
    wait_idle("rr", 100);
    check_log("rr");
    if (log_cyc.size() == 32) check("rr_contig", 32'(log_cyc[31] - log_cyc[0]), 32'd31);

    // Early last from producer 1, producer 3 takes over next cycle
    do_reset();
    load(1, 8'hA1, 1'b0);
    load(1, 8'hA2, 1'b1);
    for (int k = 0; k < 4; k++) load(3, 8'hB0 + 8'(k), 1'b0);
    expect_beat(1, 8'hA1); expect_beat(1, 8'hA2);
    for (int k = 0; k < 4; k++) expect_beat(3, 8'hB0 + 8'(k));
    drive();
    wait_idle("early", 60);
    check_log("early");
    if (log_cyc.size() == 6) check("early_contig", 32'(log_cyc[5] - log_cyc[0]), 32'd5);

    // Full stall for 5 cycles after the first beat
    do_reset();
    for (int k = 0; k < 6; k++) load(0, 8'hC0 + 8'(k), 1'b0);
    load(1, 8'hC8, 1'b1);
    for (int k = 0; k < 4; k++) expect_beat(0, 8'hC0 + 8'(k));
    expect_beat(1, 8'hC8);
    expect_beat(0, 8'hC4); expect_beat(0, 8'hC5);
    drive();
    n = 0;
    while (log_data.size() < 1 && n < 20) begin step(); n++; end
    check("stall_start", 32'(log_data.size()), 32'd1);
    wfull = 1'b1;
    repeat (5) step();
    wfull = 1'b0;
    wait_idle("stall", 60);
    check_log("stall");
    if (log_cyc.size() == 7) begin
      check("stall_gap",    32'(log_cyc[1] - log_cyc[0]), 32'd6);
      check("stall_resume", 32'(log_cyc[3] - log_cyc[1]), 32'd2);
    end

    // Reset in the middle of owner 3's burst
    do_reset();
    load(2, 8'hE0, 1'b1);
    for (int k = 0; k < 4; k++) load(3, 8'hD0 + 8'(k), 1'b0);
    expect_beat(2, 8'hE0); expect_beat(3, 8'hD0); expect_beat(3, 8'hD1);
    for (int k = 0; k < 4; k++) expect_beat(1, 8'hF0 + 8'(k));
    expect_beat(3, 8'hD2); expect_beat(3, 8'hD3);
    drive();
    n = 0;
    while (log_data.size() < 3 && n < 20) begin step(); n++; end
    check("rstmid_pre_count", 32'(log_data.size()), 32'd3);
    for (int k = 0; k < 4; k++) load(1, 8'hF0 + 8'(k), 1'b0);
    drive();
    #1;
    check("rstmid_pre_winc", 32'(winc), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_winc", 32'(winc), 32'd0);
    check("rstmid_ack",  32'(ack),  32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle("rstmid", 60);
    check_log("rstmid");
    if (log_own.size() > 3) check("rstmid_first_owner", 32'(log_own[3]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
